alu_sequencer: RTL



---
 rtl/jac_pkg.sv | 62 ++++++
 rtl/alu_sequencer_if.sv | 33 +++
 rtl/jac_regfile.sv | 43 ++++
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/jac_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : jac_pkg
// Description : Shared widths, opcodes, status bit indices, instruction field
//               helpers and sequencer state encoding for the Jac1-8 core.
// Revision    : 1.0 - initial release
// ============================================================================
package jac_pkg;

   localparam int DataWidth     = 8;
   localparam int NumOpCodeBits = 5;
   localparam int ParamBits     = 8;
   localparam int NumStatusBits = 4;
   localparam int NumRegs       = 8;
   localparam int RegIdxBits    = 3;
   localparam int InstrBits     = 16;

   localparam logic [NumOpCodeBits-1:0] OP_NOP  = 5'b0_0000;
   localparam logic [NumOpCodeBits-1:0] OP_ADD  = 5'b0_0001;
   localparam logic [NumOpCodeBits-1:0] OP_SUB  = 5'b0_0010;
   localparam logic [NumOpCodeBits-1:0] OP_AND  = 5'b0_0011;
   localparam logic [NumOpCodeBits-1:0] OP_OR   = 5'b0_0100;
   localparam logic [NumOpCodeBits-1:0] OP_XOR  = 5'b0_0101;
   localparam logic [NumOpCodeBits-1:0] OP_NOT  = 5'b0_0110;
   localparam logic [NumOpCodeBits-1:0] OP_SHL  = 5'b0_0111;
   localparam logic [NumOpCodeBits-1:0] OP_SHR  = 5'b0_1000;
   localparam logic [NumOpCodeBits-1:0] OP_VAL  = 5'b0_1001;
   localparam logic [NumOpCodeBits-1:0] OP_GOTO = 5'b1_0000;
   localparam logic [NumOpCodeBits-1:0] OP_IFZ  = 5'b1_0001;
   localparam logic [NumOpCodeBits-1:0] OP_IFNZ = 5'b1_0010;
   localparam logic [NumOpCodeBits-1:0] OP_IFEQ = 5'b1_0011;
   localparam logic [NumOpCodeBits-1:0] OP_IFST = 5'b1_0100;
   localparam logic [NumOpCodeBits-1:0] OP_IFGT = 5'b1_0101;
   localparam logic [NumOpCodeBits-1:0] OP_HALT = 5'b1_1111;

   localparam int STAT_CARRY = 0;
   localparam int STAT_UNDER = 1;
   localparam int STAT_ZERO  = 2;
   localparam int STAT_EQUAL = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   function automatic logic [NumOpCodeBits-1:0] instr_opcode(input logic [InstrBits-1:0] w);
      return w[15:11];
   endfunction

   function automatic logic [RegIdxBits-1:0] instr_ra(input logic [InstrBits-1:0] w);
      return w[10:8];
   endfunction

   function automatic logic [ParamBits-1:0] instr_param(input logic [InstrBits-1:0] w);
      return w[7:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_sequencer_if
// Description : Instruction-fetch and ALU datapath bus of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_sequencer_if;
   import jac_pkg::*;

   logic                     imem_req;
   logic [ParamBits-1:0]     imem_addr;
   logic                     imem_ack;
   logic [InstrBits-1:0]     imem_data;
   logic [NumOpCodeBits-1:0] alu_opcode;
   logic [DataWidth-1:0]     alu_operand1;
   logic [DataWidth-1:0]     alu_operand2;
   logic [ParamBits-1:0]     alu_param;
   logic [DataWidth-1:0]     alu_result;
   logic [NumStatusBits-1:0] alu_status;

   modport master (
      output imem_req, imem_addr, alu_opcode, alu_operand1, alu_operand2, alu_param,
      input  imem_ack, imem_data, alu_result, alu_status
   );

   modport slave (
      input  imem_req, imem_addr, alu_opcode, alu_operand1, alu_operand2, alu_param,
      output imem_ack, imem_data, alu_result, alu_status
   );

endinterface
`default_nettype wire

// File: rtl/jac_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : jac_regfile
// Description : 8x8 register file, two operand read ports, one debug read
//               port, one synchronous write port, synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module jac_regfile
   import jac_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic [RegIdxBits-1:0] rd_a_sel,
   input  logic [RegIdxBits-1:0] rd_b_sel,
   input  logic [RegIdxBits-1:0] dbg_sel,
   output logic [DataWidth-1:0]  rd_a_data,
   output logic [DataWidth-1:0]  rd_b_data,
   output logic [DataWidth-1:0]  dbg_data,
   input  logic                  wr_en,
   input  logic [RegIdxBits-1:0] wr_sel,
   input  logic [DataWidth-1:0]  wr_data
);

   logic [DataWidth-1:0] r_regs [NumRegs];

   // Reset wins over a coincident write so an interrupted EXEC leaves no trace.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NumRegs; i++) begin
            r_regs[i] <= '0;
         end
      end else if (wr_en) begin
         r_regs[wr_sel] <= wr_data;
      end
   end

   assign rd_a_data = r_regs[rd_a_sel];
   assign rd_b_data = r_regs[rd_b_sel];
   assign dbg_data  = r_regs[dbg_sel];

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Jac1-8 instruction sequencer: fetch, decode, ALU drive,
//               write-back and branch resolution.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
   import jac_pkg::*;
(
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     run,
   output logic                     halted,
   alu_sequencer_if.master          bus,
   input  logic [RegIdxBits-1:0]    dbg_sel,
   output logic [DataWidth-1:0]     dbg_data,
   output logic [NumStatusBits-1:0] flags
);

   state_t                   r_state;
   state_t                   w_state_next;
   logic [ParamBits-1:0]     r_pc;
   logic [ParamBits-1:0]     w_pc_next;
   logic [InstrBits-1:0]     r_ir;
   logic [NumStatusBits-1:0] r_flags;
   logic [NumStatusBits-1:0] w_flags_next;
   logic                     w_rf_we;
   logic [DataWidth-1:0]     w_rf_wdata;
   logic                     w_take;
   logic [NumOpCodeBits-1:0] w_op;
   logic [RegIdxBits-1:0]    w_ra;
   logic [ParamBits-1:0]     w_param;
   logic [DataWidth-1:0]     w_op1;
   logic [DataWidth-1:0]     w_op2;

   assign w_op    = instr_opcode(r_ir);
   assign w_ra    = instr_ra(r_ir);
   assign w_param = instr_param(r_ir);

   jac_regfile u_regfile (
      .clock     (clock),
      .reset     (reset),
      .rd_a_sel  (w_ra),
      .rd_b_sel  (w_param[RegIdxBits-1:0]),
      .dbg_sel   (dbg_sel),
      .rd_a_data (w_op1),
      .rd_b_data (w_op2),
      .dbg_data  (dbg_data),
      .wr_en     (w_rf_we),
      .wr_sel    (w_ra),
      .wr_data   (w_rf_wdata)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_pc    <= '0;
         r_ir    <= '0;
         r_flags <= '0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         r_flags <= w_flags_next;
         if (r_state == ST_FETCH && bus.imem_ack) begin
            r_ir <= bus.imem_data;
         end
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_pc_next        = r_pc;
      w_flags_next     = r_flags;
      w_rf_we          = 1'b0;
      w_rf_wdata       = bus.alu_result;
      w_take           = 1'b0;
      halted           = 1'b0;
      bus.imem_req     = 1'b0;
      bus.alu_opcode   = OP_NOP;
      bus.alu_operand1 = '0;
      bus.alu_operand2 = '0;
      bus.alu_param    = '0;

      case (r_state)
         ST_IDLE: begin
            if (run) begin
               w_state_next = ST_FETCH;
            end
         end
         ST_FETCH: begin
            bus.imem_req = 1'b1;
            if (bus.imem_ack) begin
               w_state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            bus.alu_opcode   = w_op;
            bus.alu_operand1 = w_op1;
            bus.alu_operand2 = w_op2;
            bus.alu_param    = w_param;

            if (w_op inside {[OP_ADD:OP_SHR]}) begin
               w_rf_we      = 1'b1;
               w_flags_next = bus.alu_status;
            end else if (w_op == OP_VAL) begin
               w_rf_we    = 1'b1;
               w_rf_wdata = w_param;
            end

            // Branch conditions test the flags left by earlier instructions.
            case (w_op)
               OP_GOTO: w_take = 1'b1;
               OP_IFZ:  w_take = r_flags[STAT_ZERO];
               OP_IFNZ: w_take = !r_flags[STAT_ZERO];
               OP_IFEQ: w_take = r_flags[STAT_EQUAL];
               OP_IFST: w_take = r_flags[STAT_UNDER];
               OP_IFGT: w_take = !r_flags[STAT_UNDER] && !r_flags[STAT_EQUAL];
               default: w_take = 1'b0;
            endcase

            if (w_op == OP_HALT) begin
               w_state_next = ST_HALTED;
            end else begin
               w_pc_next    = w_take ? w_param : r_pc + 8'd1;
               w_state_next = run ? ST_FETCH : ST_IDLE;
            end
         end
         ST_HALTED: begin
            halted = 1'b1;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   assign bus.imem_addr = r_pc;
   assign flags         = r_flags;

endmodule
`default_nettype wire
